// File: rtl/nn_pkg.sv
// Shared definitions for the classifier sequencer: default widths, stage timeout,
// FSM state encoding and a small state-classification helper.
// Imported by nn_input_pingpong and nn_inference_scheduler.
package nn_pkg;

    localparam int NN_INPUT_SIZE      = 256;
    localparam int NN_CLASS_BITS      = 4;
    localparam int NN_TIMEOUT_CYCLES  = 1024;
    localparam int NN_CNT_WIDTH       = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_L1_RUN = 3'd1;
    localparam state_t ST_L2_RUN = 3'd2;
    localparam state_t ST_MX_RUN = 3'd3;
    localparam state_t ST_RESULT = 3'd4;

    // True in the states where a compute stage is running and the stage timer counts.
    function automatic logic is_run_state(input state_t s);
        return (s == ST_L1_RUN) || (s == ST_L2_RUN) || (s == ST_MX_RUN);
    endfunction

endpackage

// File: rtl/nn_input_pingpong.sv
// Two-slot ping-pong image buffer between the host and layer 1.
// Latency: push visible on rd_dat/count the cycle after the push; in_ready is registered.
// Backpressure: in_ready low while both slots are full; flush empties the buffer in one cycle.
// Ports: clk/reset (async active-low), push/push_dat, pop, flush -> rd_dat (slot at rd_ptr), count, in_ready.
module nn_input_pingpong
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_INPUT_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_dat,
    output logic [1:0]       count,
    output logic             in_ready
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             push_ok, pop_ok;

    always_comb begin
        // Guards keep the occupancy sane even if a caller misbehaves.
        push_ok    = push && (count_q != 2'd2);
        pop_ok     = pop && (count_q != 2'd0);
        slot_d     = slot_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_ok) begin
                slot_d[wr_ptr_q] = push_dat;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push_ok) - 2'(pop_ok);
        end
        // Registered ready reflects the occupancy after this cycle's update.
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign rd_dat   = slot_q[rd_ptr_q];
    assign count    = count_q;
    assign in_ready = in_ready_q;

endmodule

// File: rtl/nn_inference_scheduler.sv
// Sequencer for layer 1 -> layer 2 -> max-of-10, fed from a two-slot input buffer.
// Latency: start pulse two cycles after first push; stage N+1 starts the cycle after stage N done.
// Backpressure: in_ready low when both slots full; result held until res_ready; per-stage timeout.
// Ports: host in_valid/in_ready/in_data, abort; l1/l2/mx start+done, mx_class; res_valid/res_ready/
//        res_class/res_error; busy, frame_count. reset is asynchronous active-low.
module nn_inference_scheduler
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE     = NN_INPUT_SIZE,
    parameter int CLASS_BITS     = NN_CLASS_BITS,
    parameter int TIMEOUT_CYCLES = NN_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = NN_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in_data,
    input  logic                  abort,
    output logic [INPUT_SIZE-1:0] l1_data,
    output logic                  l1_start,
    input  logic                  l1_done,
    output logic                  l2_start,
    input  logic                  l2_done,
    output logic                  mx_start,
    input  logic                  mx_done,
    input  logic [CLASS_BITS-1:0] mx_class,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CLASS_BITS-1:0] res_class,
    output logic                  res_error,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    localparam int           TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  l1_start_q, l1_start_d;
    logic                  l2_start_q, l2_start_d;
    logic                  mx_start_q, mx_start_d;
    logic                  res_valid_q, res_valid_d;
    logic [CLASS_BITS-1:0] res_class_q, res_class_d;
    logic                  res_error_q, res_error_d;
    logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;

    logic                  in_run;
    logic                  stage_done;
    logic                  stage_timeout;
    logic                  buf_push;
    logic                  buf_pop;
    logic [1:0]            buf_count;

    assign in_run = is_run_state(state_q);

    // A done is only honoured after the start pulse cycle, so a level left
    // over from the previous frame (or a done coincident with start) is ignored.
    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            ST_L1_RUN: stage_done = l1_done && !l1_start_q;
            ST_L2_RUN: stage_done = l2_done && !l2_start_q;
            ST_MX_RUN: stage_done = mx_done && !mx_start_q;
            default:   stage_done = 1'b0;
        endcase
    end

    assign stage_timeout = in_run && !stage_done && (timer_q == TIMER_LAST);
    assign buf_push      = in_valid && in_ready && !abort;
    // Layer 1 has finished with its image either way, so a layer 1 timeout also frees the slot.
    assign buf_pop       = (state_q == ST_L1_RUN) && (stage_done || stage_timeout) && !abort;

    nn_input_pingpong #(
        .WIDTH (INPUT_SIZE)
    ) u_pingpong (
        .clk      (clk),
        .reset    (reset),
        .push     (buf_push),
        .push_dat (in_data),
        .pop      (buf_pop),
        .flush    (abort),
        .rd_dat   (l1_data),
        .count    (buf_count),
        .in_ready (in_ready)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = in_run ? timer_q + TW'(1) : timer_q;
        l1_start_d    = 1'b0;
        l2_start_d    = 1'b0;
        mx_start_d    = 1'b0;
        res_valid_d   = res_valid_q;
        res_class_d   = res_class_q;
        res_error_d   = res_error_q;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (buf_count != 2'd0) begin
                    state_d    = ST_L1_RUN;
                    l1_start_d = 1'b1;
                    timer_d    = '0;
                end
            end
            ST_L1_RUN: begin
                if (stage_done) begin
                    state_d    = ST_L2_RUN;
                    l2_start_d = 1'b1;
                    timer_d    = '0;
                end
            end
            ST_L2_RUN: begin
                if (stage_done) begin
                    state_d    = ST_MX_RUN;
                    mx_start_d = 1'b1;
                    timer_d    = '0;
                end
            end
            ST_MX_RUN: begin
                if (stage_done) begin
                    state_d     = ST_RESULT;
                    res_valid_d = 1'b1;
                    res_class_d = mx_class;
                    res_error_d = 1'b0;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    frame_count_d = frame_count_q + CNT_WIDTH'(1);
                    res_valid_d   = 1'b0;
                    // Go straight to the next buffered image without an IDLE bubble.
                    if (buf_count != 2'd0) begin
                        state_d    = ST_L1_RUN;
                        l1_start_d = 1'b1;
                        timer_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stage_timeout) begin
            state_d     = ST_RESULT;
            res_valid_d = 1'b1;
            res_error_d = 1'b1;
            res_class_d = '0;
        end

        if (abort) begin
            state_d       = ST_IDLE;
            timer_d       = '0;
            l1_start_d    = 1'b0;
            l2_start_d    = 1'b0;
            mx_start_d    = 1'b0;
            res_valid_d   = 1'b0;
            frame_count_d = frame_count_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            l1_start_q    <= 1'b0;
            l2_start_q    <= 1'b0;
            mx_start_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_class_q   <= '0;
            res_error_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            l1_start_q    <= l1_start_d;
            l2_start_q    <= l2_start_d;
            mx_start_q    <= mx_start_d;
            res_valid_q   <= res_valid_d;
            res_class_q   <= res_class_d;
            res_error_q   <= res_error_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign l1_start    = l1_start_q;
    assign l2_start    = l2_start_q;
    assign mx_start    = mx_start_q;
    assign res_valid   = res_valid_q;
    assign res_class   = res_class_q;
    assign res_error   = res_error_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_nn_inference_scheduler.sv
// Bench for nn_inference_scheduler: host/stage/consumer emulation driven from one
// initial block, with a queue model of buffered images and a frame counter model.
module tb_nn_inference_scheduler;

    localparam int IW  = 256;
    localparam int CB  = 4;
    localparam int TMO = 16;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          abort;
    logic [IW-1:0] l1_data;
    logic          l1_start, l1_done;
    logic          l2_start, l2_done;
    logic          mx_start, mx_done;
    logic [CB-1:0] mx_class;
    logic          res_valid, res_ready;
    logic [CB-1:0] res_class;
    logic          res_error;
    logic          busy;
    logic [CW-1:0] frame_count;

    always #5 clk = ~clk;

    nn_inference_scheduler #(
        .INPUT_SIZE     (IW),
        .CLASS_BITS     (CB),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .abort       (abort),
        .l1_data     (l1_data),
        .l1_start    (l1_start),
        .l1_done     (l1_done),
        .l2_start    (l2_start),
        .l2_done     (l2_done),
        .mx_start    (mx_start),
        .mx_done     (mx_done),
        .mx_class    (mx_class),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_class   (res_class),
        .res_error   (res_error),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] exp_img[$];   // images the design should be holding, oldest first
    logic [IW-1:0] pend[$];      // images the host still wants to deliver
    bit            pop_pending = 0;
    bit            fc_pending  = 0;
    bit            mon_en      = 0;
    logic [CW-1:0] exp_fc      = '0;

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] rand_img();
        logic [IW-1:0] r;
        for (int i = 0; i < IW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [2:0] starts();
        return {l1_start, l2_start, mx_start};
    endfunction

    function automatic logic get_start(input int s);
        case (s)
            1:       return l1_start;
            2:       return l2_start;
            default: return mx_start;
        endcase
    endfunction

    task automatic set_done(input int s, input logic v);
        case (s)
            1:       l1_done = v;
            2:       l2_done = v;
            default: mx_done = v;
        endcase
    endtask

    task automatic host_push(input logic [IW-1:0] img);
        pend.push_back(img);
        if (!in_valid) begin
            in_valid = 1'b1;
            in_data  = pend[0];
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at this edge.
    task automatic step();
        bit acc;
        acc = in_valid && in_ready && !abort && reset;
        if (abort) begin
            exp_img.delete();
            pend.delete();
            pop_pending = 0;
            fc_pending  = 0;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            exp_img.push_back(in_data);
            pend.delete(0);
        end
        if (pop_pending) begin
            exp_img.delete(0);
            pop_pending = 0;
        end
        if (fc_pending) begin
            exp_fc++;
            fc_pending = 0;
        end
        if (pend.size() > 0) begin
            in_valid = 1'b1;
            in_data  = pend[0];
        end else begin
            in_valid = 1'b0;
        end
        if (mon_en) begin
            chk("in_ready_vs_occupancy", in_ready, exp_img.size() < 2);
            chk("frame_count", frame_count, exp_fc);
        end
    endtask

    // Entered in the stage's start-pulse cycle; leaves in the cycle after done/timeout.
    task automatic stage(input int s, input int lat, input logic [CB-1:0] cls,
                         input bit stale, output bit to);
        int k;
        to = (lat > TMO - 1);
        k  = to ? TMO - 1 : lat;
        chk("stage_start_pulse", get_start(s), 1'b1);
        chk("busy_in_run", busy, 1'b1);
        if (stale) set_done(s, 1'b1);   // done coincident with start must be ignored
        for (int c = 1; c <= k; c++) begin
            step();
            set_done(s, 1'b0);
            chk("single_start_pulse", starts(), 3'b000);
            chk("no_result_while_running", res_valid, 1'b0);
            if (!to && c == lat) begin
                set_done(s, 1'b1);
                if (s == 3) mx_class = cls;
                if (s == 1) pop_pending = 1;
            end
            if (to && c == k && s == 1) pop_pending = 1;
        end
        step();
        set_done(s, 1'b0);
        mx_class = CB'($urandom);
    endtask

    // Entered in the l1_start cycle; leaves in the first RESULT cycle.
    task automatic run_frame(input int la, input int lb, input int lc, input logic [CB-1:0] cls,
                             input bit stale, output logic [CB-1:0] ecls, output bit eerr);
        bit to;
        int lat[3];
        lat = '{la, lb, lc};
        chk("l1_data_oldest_image", l1_data, (exp_img.size() > 0) ? exp_img[0] : '0);
        to = 0;
        for (int s = 1; s <= 3; s++) begin
            if (!to) stage(s, lat[s-1], cls, stale, to);
        end
        eerr = to;
        ecls = to ? '0 : cls;
        chk("res_valid", res_valid, 1'b1);
        chk("res_error", res_error, eerr);
        chk("res_class", res_class, ecls);
        chk("no_start_at_result", starts(), 3'b000);
    endtask

    task automatic accept_result(input int hold, input logic [CB-1:0] ecls, input bit eerr);
        bit more;
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_class", res_class, ecls);
            chk("hold_res_error", res_error, eerr);
            chk("hold_no_l1_start", l1_start, 1'b0);
        end
        more       = exp_img.size() > 0;
        res_ready  = 1'b1;
        fc_pending = 1;
        step();
        res_ready = 1'b0;
        chk("res_valid_cleared", res_valid, 1'b0);
        chk("next_l1_start", l1_start, more);
        chk("busy_after_result", busy, more);
    endtask

    task automatic wait_l1();
        int n = 0;
        while (l1_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("l1_start_wait", l1_start, 1'b1);
    endtask

    initial begin
        logic [CB-1:0] ecls;
        bit            eerr;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        l1_done   = 1'b0;
        l2_done   = 1'b0;
        mx_done   = 1'b0;
        mx_class  = '0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_starts", starts(), 3'b000);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_error", res_error, 1'b0);
        chk("rst_res_class", res_class, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_count", frame_count, '0);
        chk("rst_l1_data", l1_data, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        chk("in_ready_before_edge", in_ready, 1'b0);
        step();
        chk("in_ready_after_release", in_ready, 1'b1);
        mon_en = 1;

        // Single frame, done at 5/7/3 cycles, class 7
        host_push(rand_img());
        step();
        chk("idle_no_start", l1_start, 1'b0);
        chk("idle_not_busy", busy, 1'b0);
        step();
        run_frame(5, 7, 3, 4'd7, 1'b0, ecls, eerr);
        accept_result(0, ecls, eerr);
        chk("frame_count_one", frame_count, 16'd1);

        // Three images back-to-back, consumer always ready
        host_push(rand_img());
        host_push(rand_img());
        host_push(rand_img());
        step();
        step();
        chk("in_ready_full", in_ready, 1'b0);
        for (int f = 0; f < 3; f++) begin
            if (f == 0) chk("b2b_first_start", l1_start, 1'b1);
            run_frame($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9),
                      CB'($urandom), 1'b0, ecls, eerr);
            accept_result(0, ecls, eerr);
        end
        chk("frame_count_four", frame_count, 16'd4);

        // Layer 2 timeout
        host_push(rand_img());
        wait_l1();
        run_frame(4, 40, 3, 4'd9, 1'b0, ecls, eerr);
        chk("timeout_flag", eerr, 1'b1);
        accept_result(1, ecls, eerr);

        // Consumer stalls 20 cycles with a second image buffered
        host_push(rand_img());
        host_push(rand_img());
        wait_l1();
        run_frame(2, 3, 2, 4'd5, 1'b1, ecls, eerr);
        accept_result(20, ecls, eerr);
        run_frame(3, 2, 6, 4'd2, 1'b0, ecls, eerr);
        accept_result(2, ecls, eerr);

        // Abort during MX_RUN with one image still buffered; a coincident push is dropped
        host_push(rand_img());
        host_push(rand_img());
        wait_l1();
        stage(1, 3, '0, 1'b0, eerr);
        stage(2, 2, '0, 1'b0, eerr);
        chk("mx_start_before_abort", mx_start, 1'b1);
        step();
        abort = 1'b1;
        host_push(rand_img());
        step();
        abort = 1'b0;
        chk("abort_idle", busy, 1'b0);
        chk("abort_res_valid", res_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_no_start", starts(), 3'b000);
        step();
        chk("abort_still_idle", busy, 1'b0);
        chk("abort_still_no_start", starts(), 3'b000);

        // Randomized frames: latencies past the timeout produce error results
        for (int it = 0; it < 12; it++) begin
            if (exp_img.size() + pend.size() == 0) begin
                host_push(rand_img());
                if ($urandom_range(0, 1) == 1) host_push(rand_img());
            end
            wait_l1();
            if ($urandom_range(0, 1) == 1) host_push(rand_img());
            run_frame($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 20),
                      CB'($urandom), 1'($urandom_range(0, 1)), ecls, eerr);
            accept_result($urandom_range(0, 3), ecls, eerr);
        end

        // Reset glitch between edges in the middle of L2_RUN
        while (exp_img.size() + pend.size() > 0) begin
            wait_l1();
            run_frame(2, 2, 2, 4'd1, 1'b0, ecls, eerr);
            accept_result(0, ecls, eerr);
        end
        host_push(rand_img());
        host_push(rand_img());
        wait_l1();
        stage(1, 3, '0, 1'b0, eerr);
        step();
        step();
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        exp_img.delete();
        pend.delete();
        pop_pending = 0;
        fc_pending  = 0;
        exp_fc      = '0;
        #1;
        chk("glitch_starts", starts(), 3'b000);
        chk("glitch_res_valid", res_valid, 1'b0);
        chk("glitch_res_error", res_error, 1'b0);
        chk("glitch_res_class", res_class, '0);
        chk("glitch_busy", busy, 1'b0);
        chk("glitch_frame_count", frame_count, '0);
        chk("glitch_l1_data", l1_data, '0);
        chk("glitch_in_ready", in_ready, 1'b0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_reset_no_start", starts(), 3'b000);
            chk("post_reset_idle", busy, 1'b0);
        end
        host_push(rand_img());
        step();
        chk("post_reset_idle_no_start", l1_start, 1'b0);
        step();
        run_frame(6, 1, 15, 4'd12, 1'b1, ecls, eerr);
        accept_result(0, ecls, eerr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
